// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP multiplier between two requesters.
// Latches the winner's operands, holds them for LATENCY cycles, then returns result and flags.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational
// BUSY  | operands held on the multiplier; counter runs down to 0
// RESP  | result and flags presented to the owner until it takes them
module fp_mult_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 33,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  input  logic             req_valid1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             req_ready0,
  output logic             req_ready1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_exception,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             mult_en,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_overflow,
  input  logic             mult_exception,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mult_a_q, mult_a_d;
  logic [WIDTH-1:0] mult_b_q, mult_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             exc_q, exc_d;
  logic             grant0, grant1;

  // prio only matters when both requesters are valid in the same cycle
  assign grant0 = req_valid0 & (~req_valid1 | ~prio_q);
  assign grant1 = req_valid1 & (~req_valid0 | prio_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          state_d  = BUSY;
          owner_d  = grant1;
          prio_d   = ~grant1;
          cnt_d    = CNT_LOAD;
          mult_a_d = grant1 ? req_a1 : req_a0;
          mult_b_d = grant1 ? req_b1 : req_b0;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          result_d = mult_result;
          ovf_d    = mult_overflow;
          exc_d    = mult_exception;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (owner_q ? rsp_ready1 : rsp_ready0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready0    = (state_q == IDLE) & grant0;
    req_ready1    = (state_q == IDLE) & grant1;
    rsp_valid0    = (state_q == RESP) & ~owner_q;
    rsp_valid1    = (state_q == RESP) & owner_q;
    mult_en       = (state_q == BUSY);
    busy          = (state_q != IDLE);
    mult_a        = mult_a_q;
    mult_b        = mult_b_q;
    rsp_result    = result_q;
    rsp_overflow  = ovf_q;
    rsp_exception = exc_q;
  end

endmodule
